rom_burst_arbiter: RTL
======================

Name: rom_burst_arbiter

Overview:
Round-robin arbiter and burst sequencer that shares one 16x8 asynchronous-read ROM (active-high enable, output tri-stated when disabled) between NREQ requesters. A requester posts a start address and a burst length. The block drives the ROM enable and address, registers each returned word, and delivers the words in order to the winning requester. The ROM enable is held low whenever no burst is active, so the ROM output stays high-Z when idle.

Parameters:
NREQ, 2, number of requesters (legal range 2..4)
AW, 4, ROM address width
DW, 8, ROM data width
LENW, 2, burst length field width; the burst is req_len+1 words (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  request pending, one bit per requester
req_addr  in  NREQ*AW  start address; requester i uses bits [i*AW +: AW]
req_len  in  NREQ*LENW  burst length minus 1; requester i uses bits [i*LENW +: LENW]
req_ready  out  NREQ  accept strobe; at most one bit high per cycle
rsp_valid  out  NREQ  one-hot word-valid pulse to the owner of the burst
rsp_data  out  DW  registered ROM word
rsp_last  out  1  high together with the final word of a burst
rom_en  out  1  ROM enable
rom_addr  out  AW  ROM address
rom_data  in  DW  ROM read data
busy  out  1  high while the state is READ

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE; rom_en = 0; rom_addr = 0; rsp_valid = 0; rsp_data = 0; rsp_last = 0; busy = 0; rr_ptr = NREQ-1, so requester 0 wins first. req_ready is forced to 0 while rst_n is low.
- States: IDLE, READ.
- IDLE:
  - rom_en = 0.
  - If any req_valid bit is high, choose the winner by scanning from (rr_ptr+1) mod NREQ upward, with wrap.
  - req_ready[winner] = 1, combinationally, in the same cycle. The request transfers on that edge.
  - On that edge: latch addr and len; set owner = winner; set rr_ptr = winner; go to READ.
  - req_ready is 0 for every requester in READ.
- READ:
  - rom_en = 1; rom_addr = cur_addr (registered).
  - On every edge: rsp_data <= rom_data; rsp_valid <= onehot(owner); rsp_last <= (remaining == 0).
  - If remaining != 0: cur_addr <= cur_addr + 1, modulo 2^AW (0xF wraps to 0x0); remaining decrements.
  - If remaining == 0: go to IDLE; rom_en and rom_addr are 0 in the next cycle.
- Timing, for a request accepted on the edge ending cycle T with burst length L:
  - ROM reads occur in cycles T+1 .. T+L.
  - rsp_valid is high in cycles T+2 .. T+L+1; rsp_last is high in cycle T+L+1.
  - The block is back in IDLE in cycle T+L+1 and can accept a new request that cycle. The next burst's first read is in T+L+2.
- Outside a response cycle: rsp_valid = 0 and rsp_last = 0. rsp_data holds its last value.
- A requester whose req_valid drops before acceptance is simply not granted; there is no penalty.
- A requester holding req_valid high continuously while others also request is granted at most once per NREQ grants (fairness).
- rom_data is sampled only in READ cycles; its value is ignored in IDLE, including high-Z.
- Reset mid-burst: the burst is abandoned immediately with no rsp_last, and all outputs take their reset values asynchronously.
- No backpressure on responses: the owner must accept one word per cycle.

Test Plan:
The bench connects the team's 16x8 ROM, whose contents are: 0:A9 1:FD 2:E9 3:DC 4:B9 5:C2 6:C5 7:04, with 8..F repeating 0..7.
- Idle check: after reset with all req_valid = 0 for 20 cycles -> rom_en = 0, busy = 0, rsp_valid = 0 throughout, and the ROM bus is high-Z.
- Single read: req0 addr=3 len=0 accepted in cycle T -> cycle T+1: rom_en = 1, rom_addr = 3. Cycle T+2: rsp_valid = 01, rsp_data = DC, rsp_last = 1.
- Wrap burst: req1 addr=E len=3 -> rsp_valid = 10 for 4 cycles with data C5, 04, A9, FD; rom_addr sequence E, F, 0, 1; rsp_last only on FD.
- Contention: req0 and req1 both held valid from reset, each with len=1 -> grant order 0, 1, 0, 1. Each burst's words go only to its owner, and there is exactly one IDLE cycle between bursts.
- Reset mid-burst: req0 addr=4 len=3; assert rst_n = 0 during the 2nd READ cycle -> rom_en, rsp_valid and busy go to 0 immediately with no rsp_last. After release, a new req1 addr=6 len=0 returns C5.
- NREQ=3 fairness: all three requesters valid continuously -> grants 0, 1, 2, 0, 1, 2. Dropping req_valid[1] after its first grant -> grants 0, 2, 0, 2.

Source files
------------

// File: rtl/rom_burst_arbiter_if.sv
// Request/response bus between NREQ requesters and the ROM burst arbiter.
// Requester i owns the slices [i*AW +: AW] of req_addr and [i*LENW +: LENW]
// of req_len. rsp_data and rsp_last are shared by all requesters, and the
// one-hot rsp_valid says which requester owns the word.
interface rom_burst_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int LENW = 2
) ();

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic                 rsp_last;

  // Arbiter side
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_len,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_last
  );

  // Requester side
  modport master (
    output req_valid,
    output req_addr,
    output req_len,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_last
  );

endinterface

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter and burst sequencer that shares one asynchronous-read
// ROM among NREQ requesters. A winner is picked in IDLE and acknowledged
// combinationally with req_ready. The burst is then read one word per cycle,
// and each word is registered before it goes to the owner. The ROM enable is
// low outside READ, so the ROM output floats whenever no burst is active.
module rom_burst_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8,
  parameter int LENW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_burst_arbiter_if.slave    bus,
  output logic                  rom_en,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_data,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [AW-1:0]   cur_addr_q, cur_addr_d;
  logic [LENW-1:0] remaining_q, remaining_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_last_q, rsp_last_d;

  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic            accept;
  logic [NREQ-1:0] grant_vec;

  // Round-robin scan: start one past the last winner and take the first
  // pending request, wrapping at NREQ (NREQ need not be a power of two).
  always_comb begin : arb_scan
    int idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  // Decode the winner into the ready strobe. Only IDLE accepts, and the
  // strobe is gated by rst_n so nothing can transfer while reset is held.
  always_comb begin
    accept    = (state_q == IDLE) && grant_any;
    grant_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_vec[i] = accept && (grant_idx == PW'(i));
    end
  end

  assign bus.req_ready = grant_vec & {NREQ{rst_n}};

  // ROM drive: enable and address are active only while a burst is reading,
  // so the address bus rests at zero when idle.
  assign rom_en   = (state_q == READ);
  assign rom_addr = (state_q == READ) ? cur_addr_q : '0;
  assign busy     = (state_q == READ);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;

  // Next-state logic: latch the request on acceptance, then walk the burst.
  // Each READ cycle registers the word the ROM presents for cur_addr.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_addr_d  = bus.req_addr[int'(grant_idx)*AW +: AW];
          remaining_d = bus.req_len[int'(grant_idx)*LENW +: LENW];
          owner_d     = grant_idx;
          rr_ptr_d    = grant_idx;
          state_d     = READ;
        end
      end

      READ: begin
        rsp_data_d = rom_data;
        for (int i = 0; i < NREQ; i++) begin
          rsp_valid_d[i] = (owner_q == PW'(i));
        end
        rsp_last_d = (remaining_q == '0);
        if (remaining_q != '0) begin
          // Address wraps naturally at 2^AW.
          cur_addr_d  = cur_addr_q + AW'(1);
          remaining_d = remaining_q - LENW'(1);
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers. An asynchronous reset abandons any burst
  // in flight and clears the response outputs without issuing rsp_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PW'(NREQ - 1);
      owner_q     <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

endmodule
